// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DISCARD = 2'd1,
      S_FULL    = 2'd2
   } fetch_state_t;

   localparam int          OPCODE_W          = 7;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if_id_register.sv
// rtl/fetch_unit_if_id_register.sv - IF/ID pipeline register; flush > load > stall, otherwise drains to a bubble
module if_id_register
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        flush,
   input  logic        stall,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_instruction,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic [31:0] instruction
);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid       <= 1'b0;
         pc          <= 32'd0;
         pc4         <= 32'd4;
         instruction <= NOP_INSTR;
      end else if (flush) begin
         valid       <= 1'b0;
         instruction <= NOP_INSTR;
      end else if (load) begin
         valid       <= 1'b1;
         pc          <= load_pc;
         pc4         <= load_pc + 32'd4;
         instruction <= load_instruction;
      end else if (!stall) begin
         valid       <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, imem req/ack fetch FSM with one-word skid and redirect discard
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall_i,
   input  logic                redirect_i,
   input  logic [31:0]         redirect_pc_i,
   output logic                imem_req_o,
   output logic [31:0]         imem_addr_o,
   input  logic                imem_ack_i,
   input  logic [31:0]         imem_rdata_i,
   output logic                if_id_valid_o,
   output logic [31:0]         if_id_pc_o,
   output logic [31:0]         if_id_pc4_o,
   output logic [31:0]         if_id_instruction_o,
   output logic [OPCODE_W-1:0] if_id_opcode_o,
   output logic                fetch_busy_o
);

   fetch_state_t state, next_state;
   logic [31:0]  pc;
   logic [31:0]  discard_addr;
   logic [31:0]  skid_pc;
   logic [31:0]  skid_instruction;

   logic         take;
   logic         skid_load;
   logic         reg_load;
   logic         reg_flush;
   logic [31:0]  reg_pc;
   logic [31:0]  reg_instruction;

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_FETCH: begin
            if (imem_ack_i) begin
               if (!redirect_i && stall_i && if_id_valid_o) next_state = S_FULL;
            end else if (redirect_i) begin
               next_state = S_DISCARD;
            end
         end
         S_DISCARD: if (imem_ack_i) next_state = S_FETCH;
         S_FULL:    if (redirect_i || !stall_i) next_state = S_FETCH;
         default:   next_state = S_FETCH;
      endcase
   end

   always_comb begin
      imem_req_o      = !reset && (state == S_FETCH || state == S_DISCARD);
      imem_addr_o     = (state == S_DISCARD) ? discard_addr : pc;
      fetch_busy_o    = (state != S_FETCH);
      take            = (state == S_FETCH) && imem_ack_i && !redirect_i;
      skid_load       = take && stall_i && if_id_valid_o;
      reg_flush       = redirect_i || (state == S_DISCARD);
      reg_load        = (take && !(stall_i && if_id_valid_o))
                     || ((state == S_FULL) && !stall_i && !redirect_i);
      reg_pc          = (state == S_FULL) ? skid_pc : pc;
      reg_instruction = (state == S_FULL) ? skid_instruction : imem_rdata_i;
   end

   // Redirect retargets the PC from any state; the discard state keeps the old address on the bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc               <= RESET_PC;
         discard_addr     <= RESET_PC;
         skid_pc          <= 32'd0;
         skid_instruction <= NOP_INSTR;
      end else begin
         if (redirect_i)  pc <= word_align(redirect_pc_i);
         else if (take)   pc <= pc + 32'd4;
         if (state == S_FETCH && !imem_ack_i && redirect_i) discard_addr <= pc;
         if (skid_load) begin
            skid_pc          <= pc;
            skid_instruction <= imem_rdata_i;
         end
      end
   end

   if_id_register #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk              (clk),
      .reset            (reset),
      .load             (reg_load),
      .flush            (reg_flush),
      .stall            (stall_i),
      .load_pc          (reg_pc),
      .load_instruction (reg_instruction),
      .valid            (if_id_valid_o),
      .pc               (if_id_pc_o),
      .pc4              (if_id_pc4_o),
      .instruction      (if_id_instruction_o)
   );

   assign if_id_opcode_o = if_id_instruction_o[OPCODE_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scenarios plus randomized stall/redirect/latency against an in-order stream model
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic        if_id_valid_o;
   logic [31:0] if_id_pc_o;
   logic [31:0] if_id_pc4_o;
   logic [31:0] if_id_instruction_o;
   logic [6:0]  if_id_opcode_o;
   logic        fetch_busy_o;

   int n_cmp = 0;
   int n_bad = 0;
   int mem_lat = 0;
   int wait_cnt = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0040_0000) return 32'h0050_0093;
      if (a == 32'h0040_0004) return 32'h00A0_0113;
      return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5BD1_E995;
   endfunction

   // Memory: acks after mem_lat wait cycles of an outstanding request
   assign imem_ack_i   = imem_req_o && (wait_cnt >= mem_lat);
   assign imem_rdata_i = mem_word(imem_addr_o);
   always @(posedge clk) begin
      if (reset || !imem_req_o || imem_ack_i) wait_cnt <= 0;
      else                                    wait_cnt <= wait_cnt + 1;
   end

   fetch_unit dut (
      .clk                 (clk),
      .reset               (reset),
      .stall_i             (stall_i),
      .redirect_i          (redirect_i),
      .redirect_pc_i       (redirect_pc_i),
      .imem_req_o          (imem_req_o),
      .imem_addr_o         (imem_addr_o),
      .imem_ack_i          (imem_ack_i),
      .imem_rdata_i        (imem_rdata_i),
      .if_id_valid_o       (if_id_valid_o),
      .if_id_pc_o          (if_id_pc_o),
      .if_id_pc4_o         (if_id_pc4_o),
      .if_id_instruction_o (if_id_instruction_o),
      .if_id_opcode_o      (if_id_opcode_o),
      .fetch_busy_o        (fetch_busy_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0; mem_lat = 0;
      tick(); tick();
      n_cmp++; if (if_id_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0h exp=0", if_id_valid_o); end
      n_cmp++; if (if_id_pc_o !== 32'd0) begin n_bad++; $display("FAIL reset_pc got=%0h exp=0", if_id_pc_o); end
      n_cmp++; if (if_id_pc4_o !== 32'd4) begin n_bad++; $display("FAIL reset_pc4 got=%0h exp=4", if_id_pc4_o); end
      n_cmp++; if (if_id_instruction_o !== NOP) begin n_bad++; $display("FAIL reset_instr got=%0h exp=%0h", if_id_instruction_o, NOP); end
      n_cmp++; if (if_id_opcode_o !== 7'h13) begin n_bad++; $display("FAIL reset_opcode got=%0h exp=13", if_id_opcode_o); end
      n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%0h exp=0", imem_req_o); end
      n_cmp++; if (fetch_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0h exp=0", fetch_busy_o); end
   endtask

   task automatic test_zero_wait();
      mem_lat = 0;
      reset = 1'b0;
      #1;
      n_cmp++; if (imem_req_o !== 1'b1) begin n_bad++; $display("FAIL zw_req got=%0h exp=1", imem_req_o); end
      n_cmp++; if (imem_addr_o !== RST_PC) begin n_bad++; $display("FAIL zw_addr got=%0h exp=%0h", imem_addr_o, RST_PC); end
      tick();
      n_cmp++; if (if_id_valid_o !== 1'b1) begin n_bad++; $display("FAIL zw_valid0 got=%0h exp=1", if_id_valid_o); end
      n_cmp++; if (if_id_pc_o !== 32'h0040_0000) begin n_bad++; $display("FAIL zw_pc0 got=%0h exp=400000", if_id_pc_o); end
      n_cmp++; if (if_id_pc4_o !== 32'h0040_0004) begin n_bad++; $display("FAIL zw_pc4_0 got=%0h exp=400004", if_id_pc4_o); end
      n_cmp++; if (if_id_instruction_o !== 32'h0050_0093) begin n_bad++; $display("FAIL zw_instr0 got=%0h exp=500093", if_id_instruction_o); end
      n_cmp++; if (if_id_opcode_o !== 7'h13) begin n_bad++; $display("FAIL zw_opcode0 got=%0h exp=13", if_id_opcode_o); end
      tick();
      n_cmp++; if (if_id_valid_o !== 1'b1) begin n_bad++; $display("FAIL zw_valid1 got=%0h exp=1", if_id_valid_o); end
      n_cmp++; if (if_id_pc_o !== 32'h0040_0004) begin n_bad++; $display("FAIL zw_pc1 got=%0h exp=400004", if_id_pc_o); end
      n_cmp++; if (if_id_instruction_o !== 32'h00A0_0113) begin n_bad++; $display("FAIL zw_instr1 got=%0h exp=a00113", if_id_instruction_o); end
   endtask

   task automatic test_stall_skid();
      int req_low;
      req_low = 0;
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (!imem_req_o) req_low++;
         tick();
         n_cmp++; if (if_id_pc_o !== 32'h0040_0004 || if_id_valid_o !== 1'b1) begin n_bad++; $display("FAIL stall_freeze_pc cyc=%0d got=%0h/%0h exp=400004/1", i, if_id_pc_o, if_id_valid_o); end
         n_cmp++; if (if_id_instruction_o !== 32'h00A0_0113) begin n_bad++; $display("FAIL stall_freeze_instr cyc=%0d got=%0h exp=a00113", i, if_id_instruction_o); end
      end
      n_cmp++; if (req_low !== 2) begin n_bad++; $display("FAIL stall_req_low got=%0d exp=2", req_low); end
      stall_i = 1'b0;
      tick();
      n_cmp++; if (if_id_pc_o !== 32'h0040_0008 || if_id_instruction_o !== mem_word(32'h0040_0008)) begin n_bad++; $display("FAIL skid_release got=%0h/%0h exp=400008/%0h", if_id_pc_o, if_id_instruction_o, mem_word(32'h0040_0008)); end
      tick();
      n_cmp++; if (if_id_pc_o !== 32'h0040_000C || if_id_valid_o !== 1'b1) begin n_bad++; $display("FAIL skid_next got=%0h/%0h exp=40000c/1", if_id_pc_o, if_id_valid_o); end
   endtask

   task automatic test_discard();
      int  iters;
      int  n;
      logic got_ack;
      logic done;
      reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
      tick(); tick();
      mem_lat = 3;
      reset = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h0040_0103;
      tick();
      redirect_i = 1'b0;
      done = 1'b0; iters = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         #1;
         n_cmp++; if (imem_addr_o !== RST_PC || imem_req_o !== 1'b1 || if_id_valid_o !== 1'b0) begin n_bad++; $display("FAIL discard_hold cyc=%0d addr=%0h req=%0h valid=%0h exp=%0h/1/0", c, imem_addr_o, imem_req_o, if_id_valid_o, RST_PC); end
         got_ack = imem_ack_i;
         tick();
         iters++;
         if (got_ack) done = 1'b1;
      end
      n_cmp++; if (done !== 1'b1 || iters !== 3) begin n_bad++; $display("FAIL discard_ack done=%0h iters=%0d exp=1/3", done, iters); end
      n_cmp++; if (imem_addr_o !== 32'h0040_0100 || if_id_valid_o !== 1'b0) begin n_bad++; $display("FAIL discard_newaddr addr=%0h valid=%0h exp=400100/0", imem_addr_o, if_id_valid_o); end
      n = 0;
      while (!if_id_valid_o && n < 10) begin tick(); n++; end
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL discard_latency got=%0d exp=4", n); end
      n_cmp++; if (if_id_pc_o !== 32'h0040_0100 || if_id_instruction_o !== mem_word(32'h0040_0100)) begin n_bad++; $display("FAIL discard_target got=%0h/%0h exp=400100/%0h", if_id_pc_o, if_id_instruction_o, mem_word(32'h0040_0100)); end
   endtask

   task automatic test_flush_beats_stall();
      mem_lat = 0; stall_i = 1'b0;
      tick(); tick();
      stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0040_0202;
      #1;
      n_cmp++; if (imem_ack_i !== 1'b1 || if_id_valid_o !== 1'b1) begin n_bad++; $display("FAIL fbs_pre ack=%0h valid=%0h exp=1/1", imem_ack_i, if_id_valid_o); end
      tick();
      redirect_i = 1'b0;
      n_cmp++; if (if_id_valid_o !== 1'b0 || if_id_instruction_o !== NOP) begin n_bad++; $display("FAIL fbs_flush valid=%0h instr=%0h exp=0/%0h", if_id_valid_o, if_id_instruction_o, NOP); end
      n_cmp++; if (imem_addr_o !== 32'h0040_0200 || imem_req_o !== 1'b1) begin n_bad++; $display("FAIL fbs_addr got=%0h req=%0h exp=400200/1", imem_addr_o, imem_req_o); end
      tick();
      n_cmp++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0040_0200) begin n_bad++; $display("FAIL fbs_refill valid=%0h pc=%0h exp=1/400200", if_id_valid_o, if_id_pc_o); end
      stall_i = 1'b0;
   endtask

   task automatic test_pc_wrap();
      stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
      tick();
      redirect_i = 1'b0;
      n_cmp++; if (imem_addr_o !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr got=%0h exp=fffffffc", imem_addr_o); end
      tick();
      n_cmp++; if (if_id_pc_o !== 32'hFFFF_FFFC || if_id_pc4_o !== 32'd0) begin n_bad++; $display("FAIL wrap_pc4 pc=%0h pc4=%0h exp=fffffffc/0", if_id_pc_o, if_id_pc4_o); end
      n_cmp++; if (imem_addr_o !== 32'd0) begin n_bad++; $display("FAIL wrap_next_addr got=%0h exp=0", imem_addr_o); end
   endtask

   task automatic test_reset_in_full();
      mem_lat = 0; stall_i = 1'b0;
      tick();
      stall_i = 1'b1;
      tick();
      n_cmp++; if (fetch_busy_o !== 1'b1 || imem_req_o !== 1'b0) begin n_bad++; $display("FAIL full_enter busy=%0h req=%0h exp=1/0", fetch_busy_o, imem_req_o); end
      reset = 1'b1;
      tick();
      stall_i = 1'b0;
      n_cmp++; if (if_id_valid_o !== 1'b0 || if_id_instruction_o !== NOP || imem_req_o !== 1'b0) begin n_bad++; $display("FAIL full_reset valid=%0h instr=%0h req=%0h exp=0/%0h/0", if_id_valid_o, if_id_instruction_o, imem_req_o, NOP); end
      reset = 1'b0;
      #1;
      n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC || fetch_busy_o !== 1'b0) begin n_bad++; $display("FAIL full_restart req=%0h addr=%0h busy=%0h exp=1/%0h/0", imem_req_o, imem_addr_o, fetch_busy_o, RST_PC); end
   endtask

   // Decode must see an unbroken +4 stream restarting at each aligned redirect target.
   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] tgt;
      logic        p_valid, p_stall, p_redir, p_req, p_ack;
      logic [31:0] p_pc, p_pc4, p_instr, p_addr;
      int          consumed;
      reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
      tick(); tick();
      reset = 1'b0;
      exp_pc = RST_PC; consumed = 0; tgt = 32'd0;
      for (int c = 0; c < 4000; c++) begin
         stall_i    = ($urandom_range(0, 99) < 30);
         redirect_i = ($urandom_range(0, 99) < 5);
         redirect_pc_i = $urandom;
         if ($urandom_range(0, 7) == 0) mem_lat = $urandom_range(0, 3);
         #1;
         p_valid = if_id_valid_o; p_stall = stall_i; p_redir = redirect_i;
         p_req = imem_req_o; p_ack = imem_ack_i; p_addr = imem_addr_o;
         p_pc = if_id_pc_o; p_pc4 = if_id_pc4_o; p_instr = if_id_instruction_o;
         tgt = redirect_pc_i & 32'hFFFF_FFFC;
         tick();
         if (p_req) begin
            n_cmp++; if (p_addr[1:0] !== 2'b00) begin n_bad++; $display("FAIL rnd_align cyc=%0d addr=%0h", c, p_addr); end
         end
         if (p_req && !p_ack) begin
            n_cmp++; if (imem_addr_o !== p_addr) begin n_bad++; $display("FAIL rnd_addr_stable cyc=%0d got=%0h exp=%0h", c, imem_addr_o, p_addr); end
         end
         if (p_redir) begin
            exp_pc = tgt;
            n_cmp++; if (if_id_valid_o !== 1'b0) begin n_bad++; $display("FAIL rnd_flush cyc=%0d valid=%0h exp=0", c, if_id_valid_o); end
         end else if (p_valid && !p_stall) begin
            consumed++;
            n_cmp++; if (p_pc !== exp_pc || p_pc4 !== exp_pc + 32'd4) begin n_bad++; $display("FAIL rnd_pc cyc=%0d got=%0h/%0h exp=%0h/%0h", c, p_pc, p_pc4, exp_pc, exp_pc + 32'd4); end
            n_cmp++; if (p_instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL rnd_instr cyc=%0d got=%0h exp=%0h", c, p_instr, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
         end else if (p_valid && p_stall) begin
            n_cmp++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== p_pc || if_id_pc4_o !== p_pc4 || if_id_instruction_o !== p_instr) begin n_bad++; $display("FAIL rnd_freeze cyc=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, if_id_pc_o, if_id_pc4_o, if_id_instruction_o, p_pc, p_pc4, p_instr); end
         end
         n_cmp++; if (if_id_opcode_o !== if_id_instruction_o[6:0]) begin n_bad++; $display("FAIL rnd_opcode cyc=%0d got=%0h exp=%0h", c, if_id_opcode_o, if_id_instruction_o[6:0]); end
      end
      stall_i = 1'b0; redirect_i = 1'b0;
      n_cmp++; if (consumed < 300) begin n_bad++; $display("FAIL rnd_progress got=%0d exp>=300", consumed); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
      test_reset();
      test_zero_wait();
      test_stall_skid();
      test_discard();
      test_flush_beats_stall();
      test_pc_wrap();
      test_reset_in_full();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
